seg7_scan: RTL and testbench

//  Downstream of time_count: multiplexes its four BCD digits onto a 4-digit common-anode 7-seg display.

---
 rtl/eggtimer_pkg.sv | 32 +++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/seg7_scan.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/eggtimer_pkg.sv
// eggtimer_pkg: shared seven-segment cathode patterns and digit positions
// for the egg-timer display path.
package eggtimer_pkg;

  // Cathode patterns, bit order {g,f,e,d,c,b,a}, active-low (0 = segment lit).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scan positions; anode bit n belongs to position n.
  localparam logic [1:0] DIGIT_SEC  = 2'd0;
  localparam logic [1:0] DIGIT_TSEC = 2'd1;
  localparam logic [1:0] DIGIT_MIN  = 2'd2;
  localparam logic [1:0] DIGIT_TMIN = 2'd3;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low one-cold anode enable for a scan position.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    anode_for = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low 7-segment cathode pattern.
// Non-decimal codes show a dash so a bad upstream value is visible, not hidden.
module bcd_to_seg7
  import eggtimer_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Select the segment pattern, forcing all segments dark when blanked.
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode display.
// Scans one digit per REFRESH_COUNT clocks, blanks the anodes for the first
// clock of every digit slot (anti-ghosting), latches all inputs once per
// frame so a frame is always self-consistent, and blinks while alarm is set.
module seg7_scan
  import eggtimer_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter int CTR_WIDTH     = 17,
  parameter int BLINK_FRAMES  = 125,
  parameter int BLINK_WIDTH   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seconds,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_minutes,
  input  logic       blank_leading,
  input  logic       colon_en,
  input  logic       alarm,
  output logic [3:0] anode,
  output logic [6:0] cathode,
  output logic       dp
);

  localparam logic [CTR_WIDTH-1:0]   CTR_LAST   = CTR_WIDTH'(REFRESH_COUNT - 1);
  localparam logic [BLINK_WIDTH-1:0] BLINK_LAST = BLINK_WIDTH'(BLINK_FRAMES - 1);

  logic [CTR_WIDTH-1:0]   ctr_q, ctr_d;
  logic [1:0]             idx_q, idx_d;
  logic [BLINK_WIDTH-1:0] blink_q, blink_d;
  logic                   phase_on_q, phase_on_d;
  logic [3:0]             snap_sec_q, snap_sec_d, snap_tsec_q, snap_tsec_d;
  logic [3:0]             snap_min_q, snap_min_d, snap_tmin_q, snap_tmin_d;
  logic                   snap_blank_q, snap_blank_d, snap_colon_q, snap_colon_d;
  logic                   snap_alarm_q, snap_alarm_d;
  logic [3:0]             anode_q, anode_d;
  logic [6:0]             cathode_q, cathode_d;
  logic                   dp_q, dp_d;

  logic                   frame_end_s;
  logic [3:0]             digit_s;
  logic                   blank_s;
  logic                   dark_s;
  logic [6:0]             seg_s;

  // Refresh/scan counters, per-frame input snapshot and blink phase.
  always_comb begin
    ctr_d        = ctr_q;
    idx_d        = idx_q;
    blink_d      = blink_q;
    phase_on_d   = phase_on_q;
    snap_sec_d   = snap_sec_q;
    snap_tsec_d  = snap_tsec_q;
    snap_min_d   = snap_min_q;
    snap_tmin_d  = snap_tmin_q;
    snap_blank_d = snap_blank_q;
    snap_colon_d = snap_colon_q;
    snap_alarm_d = snap_alarm_q;
    frame_end_s  = (ctr_q == CTR_LAST) && (idx_q == DIGIT_TMIN);
    if (ctr_q == CTR_LAST) begin
      ctr_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      ctr_d = ctr_q + CTR_WIDTH'(1);
    end
    if (frame_end_s) begin
      snap_sec_d   = seconds;
      snap_tsec_d  = tens_seconds;
      snap_min_d   = minutes;
      snap_tmin_d  = tens_minutes;
      snap_blank_d = blank_leading;
      snap_colon_d = colon_en;
      snap_alarm_d = alarm;
      // Blink only counts across frames where alarm stays set, so every new
      // alarm starts with a full visible half-period.
      if (snap_alarm_q && alarm) begin
        if (blink_q == BLINK_LAST) begin
          blink_d    = '0;
          phase_on_d = ~phase_on_q;
        end else begin
          blink_d    = blink_q + BLINK_WIDTH'(1);
        end
      end else begin
        blink_d    = '0;
        phase_on_d = 1'b1;
      end
    end else begin
      blink_d = blink_q;
    end
  end

  // Digit select and leading-zero blanking, evaluated on next-state values
  // so the registered outputs line up with the counters.
  always_comb begin
    digit_s = snap_sec_d;
    blank_s = 1'b0;
    case (idx_d)
      DIGIT_SEC:  digit_s = snap_sec_d;
      DIGIT_TSEC: digit_s = snap_tsec_d;
      DIGIT_MIN:  digit_s = snap_min_d;
      DIGIT_TMIN: digit_s = snap_tmin_d;
      default:    digit_s = snap_sec_d;
    endcase
    if (snap_blank_d) begin
      case (idx_d)
        DIGIT_TMIN: blank_s = (snap_tmin_d == 4'd0);
        DIGIT_MIN:  blank_s = (snap_tmin_d == 4'd0) && (snap_min_d == 4'd0);
        DIGIT_TSEC: blank_s = (snap_tmin_d == 4'd0) && (snap_min_d == 4'd0)
                              && (snap_tsec_d == 4'd0);
        default:    blank_s = 1'b0;
      endcase
    end else begin
      blank_s = 1'b0;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (digit_s),
    .blank_i (blank_s),
    .seg_o   (seg_s)
  );

  // Output pattern: dark blink phase, anti-ghost slot, then normal digit.
  always_comb begin
    dark_s    = snap_alarm_d && !phase_on_d;
    anode_d   = ANODE_OFF;
    cathode_d = SEG_BLANK;
    dp_d      = 1'b1;
    if (dark_s) begin
      anode_d   = ANODE_OFF;
      cathode_d = SEG_BLANK;
      dp_d      = 1'b1;
    end else begin
      anode_d   = (ctr_d == '0) ? ANODE_OFF : anode_for(idx_d);
      cathode_d = seg_s;
      dp_d      = !((idx_d == DIGIT_TSEC) && snap_colon_d);
    end
  end

  // State registers. The blanking snapshot comes out of reset set, so an
  // all-zero snapshot shows "   0" rather than "0000" in the first frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctr_q        <= '0;
      idx_q        <= 2'd0;
      blink_q      <= '0;
      phase_on_q   <= 1'b1;
      snap_sec_q   <= 4'd0;
      snap_tsec_q  <= 4'd0;
      snap_min_q   <= 4'd0;
      snap_tmin_q  <= 4'd0;
      snap_blank_q <= 1'b1;
      snap_colon_q <= 1'b0;
      snap_alarm_q <= 1'b0;
    end else begin
      ctr_q        <= ctr_d;
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      phase_on_q   <= phase_on_d;
      snap_sec_q   <= snap_sec_d;
      snap_tsec_q  <= snap_tsec_d;
      snap_min_q   <= snap_min_d;
      snap_tmin_q  <= snap_tmin_d;
      snap_blank_q <= snap_blank_d;
      snap_colon_q <= snap_colon_d;
      snap_alarm_q <= snap_alarm_d;
    end
  end

  // Output registers, all dark in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_q   <= ANODE_OFF;
      cathode_q <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: behavioural reference model plus every-cycle compare, with
// directed scenarios pinned by literal values and a randomized soak.
module tb_seg7_scan;

  localparam int RC    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] seconds = 4'd0, tens_seconds = 4'd0, minutes = 4'd0, tens_minutes = 4'd0;
  logic       blank_leading = 1'b0, colon_en = 1'b0, alarm = 1'b0;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       dp;

  int total = 0;
  int bad = 0;
  bit run_chk = 1'b0;

  seg7_scan #(.REFRESH_COUNT(RC), .CTR_WIDTH(2), .BLINK_FRAMES(BF), .BLINK_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .tens_seconds(tens_seconds),
    .minutes(minutes), .tens_minutes(tens_minutes), .blank_leading(blank_leading),
    .colon_en(colon_en), .alarm(alarm), .anode(anode), .cathode(cathode), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model: t = clock edges since reset release; frame snapshot of
  // inputs; k = index of the current frame within an unbroken alarm run.
  int         t = 0;
  int         k = 0;
  logic [3:0] m_dig [0:3] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_blank = 1'b1, m_colon = 1'b0, m_alarm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    bit lead;
    lead = m_blank && (idx > 0);
    for (int j = idx; j < 4; j++) if (m_dig[j] != 4'd0) lead = 1'b0;
    if (lead) return 7'h7F;
    if (m_dig[idx] > 4'd9) return 7'h3F;
    return seg_tab[m_dig[idx]];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      t = 0; k = 0;
      for (int j = 0; j < 4; j++) m_dig[j] = 4'd0;
      m_blank = 1'b1; m_colon = 1'b0; m_alarm = 1'b0;
    end else begin
      if ((t + 1) % FRAME == 0) begin
        k = (m_alarm && alarm) ? k + 1 : 0;
        m_dig[0] = seconds; m_dig[1] = tens_seconds;
        m_dig[2] = minutes; m_dig[3] = tens_minutes;
        m_blank = blank_leading; m_colon = colon_en; m_alarm = alarm;
      end
      t = t + 1;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  int         e_ctr, e_idx;
  logic [3:0] e_an;
  logic       e_dp;
  initial forever begin
    @(negedge clk);
    if (run_chk) begin
      if (!reset) begin
        chk("m_rst_anode", anode, 4'hF);
        chk("m_rst_cathode", cathode, 7'h7F);
        chk("m_rst_dp", dp, 1'b1);
      end else begin
        e_ctr = t % RC;
        e_idx = (t / RC) % 4;
        if (m_alarm && ((k / BF) % 2 == 1)) begin
          chk("m_dark_anode", anode, 4'hF);
          chk("m_dark_cathode", cathode, 7'h7F);
          chk("m_dark_dp", dp, 1'b1);
        end else if (e_ctr == 0) begin
          chk("m_ghost_anode", anode, 4'hF);
        end else begin
          e_an = 4'hF ^ (4'b0001 << e_idx);
          e_dp = (e_idx == 1 && m_colon) ? 1'b0 : 1'b1;
          chk("m_anode", anode, e_an);
          chk("m_dp", dp, e_dp);
          if (t >= FRAME) chk("m_cathode", cathode, exp_seg(e_idx));
        end
      end
    end
  end

  // Advance to the next negedge where the scan sits at (idx, ctr).
  task automatic goto(input int idx, input int ctr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((t % FRAME) != idx * RC + ctr && n < 2 * FRAME + 2);
    if ((t % FRAME) != idx * RC + ctr) begin
      total++; bad++;
      $display("FAIL goto_timeout: got pos %0d expected %0d", t % FRAME, idx * RC + ctr);
    end
  endtask

  task automatic set_digits(input logic [3:0] tm, input logic [3:0] m,
                            input logic [3:0] ts, input logic [3:0] s);
    tens_minutes = tm; minutes = m; tens_seconds = ts; seconds = s;
  endtask

  initial begin
    #1 run_chk = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_anode", anode, 4'b1111);
    chk("rst_cathode", cathode, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    reset = 1'b1;

    // Scan order and anti-ghost slot.
    goto(0, 1); chk("scan0", anode, 4'b1110);
    goto(1, 1); chk("scan1", anode, 4'b1101);
    goto(2, 3); chk("scan2", anode, 4'b1011);
    goto(3, 1); chk("scan3", anode, 4'b0111);
    goto(0, 0); chk("ghost", anode, 4'b1111);

    // Digits 1,2,3,4 with colon.
    goto(1, 2); set_digits(4'd1, 4'd2, 4'd3, 4'd4); colon_en = 1'b1;
    goto(0, 0);
    goto(0, 1); chk("d_idx0", cathode, 7'h19); chk("dp_idx0", dp, 1'b1);
    goto(1, 1); chk("d_idx1", cathode, 7'h30); chk("dp_idx1", dp, 1'b0);
    goto(2, 1); chk("d_idx2", cathode, 7'h24);
    goto(3, 1); chk("d_idx3", cathode, 7'h79); chk("dp_idx3", dp, 1'b1);

    // Mid-frame change is held until the next frame.
    goto(0, 2); seconds = 4'd5;
    goto(0, 3); chk("snap_hold", cathode, 7'h19);
    goto(0, 1); chk("snap_new", cathode, 7'h12);

    // Leading-zero blanking.
    blank_leading = 1'b1; set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    goto(0, 0);
    goto(1, 1); chk("blk_idx1", cathode, 7'h7F);
    goto(2, 1); chk("blk_idx2", cathode, 7'h7F);
    goto(3, 1); chk("blk_idx3", cathode, 7'h7F);
    goto(0, 1); chk("blk_idx0", cathode, 7'h78);
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    goto(0, 0);
    goto(1, 1); chk("blk2_idx1", cathode, 7'h40); chk("blk2_dp", dp, 1'b0);
    goto(2, 1); chk("blk2_idx2", cathode, 7'h12);
    goto(3, 1); chk("blk2_idx3", cathode, 7'h7F);

    // Out-of-range digit shows a dash.
    blank_leading = 1'b0; tens_seconds = 4'hC;
    goto(0, 0);
    goto(1, 1); chk("dash", cathode, 7'h3F);

    // Alarm blink: 2 frames on, 2 dark, drop during dark.
    alarm = 1'b1;
    goto(0, 0); goto(1, 1); chk("alm_on_a", anode, 4'b1101);
    goto(0, 0); goto(1, 1); chk("alm_on_b", anode, 4'b1101);
    goto(0, 0); goto(1, 1); chk("alm_dark_c", anode, 4'b1111);
    chk("alm_dark_cath", cathode, 7'h7F);
    goto(0, 0); goto(1, 1); chk("alm_dark_d", anode, 4'b1111);
    goto(0, 0); goto(1, 1); chk("alm_on_e", anode, 4'b1101);
    goto(0, 0); goto(0, 0); goto(1, 2); chk("alm_dark_g", anode, 4'b1111);
    alarm = 1'b0;
    goto(0, 0); goto(1, 1); chk("alm_drop", anode, 4'b1101);

    // Asynchronous reset mid-frame.
    goto(2, 2);
    #2 reset = 1'b0;
    #1 chk("arst_anode", anode, 4'b1111);
    chk("arst_cathode", cathode, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    @(negedge clk) reset = 1'b1;
    goto(0, 1); chk("arst_scan0", anode, 4'b1110);

    // Randomized soak checked by the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        seconds      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        tens_seconds = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        minutes      = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        tens_minutes = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        blank_leading = 1'($urandom_range(0, 1));
        colon_en      = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 40) == 0) alarm = ~alarm;
      if (c == 300) begin
        #3 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
